// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: sequential advance, branch/jump redirect with one-cycle bubble, stall hold.
// Latency: one edge from input to every output, and all outputs are registered. Stall holds the PC and drops pc_valid, but never blocks a redirect.
// Optional: define PC_ALIGN_CHECK_EN to clear bit 0 of odd jump targets and latch align_fault.
module pc_sequencer #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          PC_INC   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_pc,
   input  logic [12:0] offset_shifted,
   input  logic        jump_req,
   input  logic [15:0] jump_target,
   output logic [15:0] pc,
   output logic        pc_valid,
   output logic        redirect,
   output logic [7:0]  redirect_count,
   output logic        align_fault
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      STALL  = 2'd1,
      BUBBLE = 2'd2
   } state_t;

   localparam logic [15:0] INC = 16'(PC_INC);

   state_t      state;
   logic [15:0] br_target;
   logic [15:0] jmp_target;
   logic        jmp_misalign;
   logic        redir_any;
   logic [15:0] redir_target;

   // Branch target is relative to the instruction after the branch; wraps silently.
   assign br_target = branch_pc + INC + {{3{offset_shifted[12]}}, offset_shifted};

`ifdef PC_ALIGN_CHECK_EN
   assign jmp_target   = {jump_target[15:1], 1'b0};
   assign jmp_misalign = jump_target[0];
`else
   assign jmp_target   = jump_target;
   assign jmp_misalign = 1'b0;
`endif

   // The branch is the older instruction, so it wins over a same-cycle jump.
   assign redir_any    = branch_taken | jump_req;
   assign redir_target = branch_taken ? br_target : jmp_target;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc             <= RESET_PC;
         state          <= BUBBLE;
         pc_valid       <= 1'b0;
         redirect       <= 1'b0;
         redirect_count <= 8'h00;
         align_fault    <= 1'b0;
      end else if (redir_any) begin
         pc       <= redir_target;
         state    <= BUBBLE;
         pc_valid <= 1'b0;
         redirect <= 1'b1;
         if (redirect_count != 8'hFF)
            redirect_count <= redirect_count + 8'd1;
         if (!branch_taken && jmp_misalign)
            align_fault <= 1'b1;
      end else begin
         redirect <= 1'b0;
         case (state)
            RUN: begin
               if (stall) begin
                  state    <= STALL;
                  pc_valid <= 1'b0;
               end else begin
                  pc       <= pc + INC;
                  pc_valid <= 1'b1;
               end
            end
            STALL, BUBBLE: begin
               // Leaving a bubble or stall fetches the held PC before advancing.
               if (stall) begin
                  state    <= STALL;
                  pc_valid <= 1'b0;
               end else begin
                  state    <= RUN;
                  pc_valid <= 1'b1;
               end
            end
            default: begin
               state    <= BUBBLE;
               pc_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer: the driver queues the expected outputs, and a monitor compares them after each edge.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_pc;
   logic [12:0] offset_shifted;
   logic        jump_req;
   logic [15:0] jump_target;
   logic [15:0] pc;
   logic        pc_valid;
   logic        redirect;
   logic [7:0]  redirect_count;
   logic        align_fault;

   typedef struct packed {
      logic [15:0] pc;
      logic        vld;
      logic        rd;
      logic [7:0]  cnt;
      logic        af;
   } exp_t;

   exp_t  exp_q[$];
   string nm_q[$];
   int    total = 0;
   int    bad   = 0;

`ifdef PC_ALIGN_CHECK_EN
   localparam logic [15:0] ODD_JPC = 16'h0300;
   localparam logic        ODD_AF  = 1'b1;
`else
   localparam logic [15:0] ODD_JPC = 16'h0301;
   localparam logic        ODD_AF  = 1'b0;
`endif

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .branch_taken   (branch_taken),
      .branch_pc      (branch_pc),
      .offset_shifted (offset_shifted),
      .jump_req       (jump_req),
      .jump_target    (jump_target),
      .pc             (pc),
      .pc_valid       (pc_valid),
      .redirect       (redirect),
      .redirect_count (redirect_count),
      .align_fault    (align_fault)
   );

   // Drive one cycle of inputs at the negedge and queue the outputs expected after the next posedge.
   task automatic step(input logic r, input logic s, input logic b, input logic [15:0] bp,
                       input logic [12:0] of, input logic j, input logic [15:0] jt,
                       input logic [15:0] e_pc, input logic e_v, input logic e_r,
                       input logic [7:0] e_c, input logic e_a, input string nm);
      exp_t e;
      reset          = r;
      stall          = s;
      branch_taken   = b;
      branch_pc      = bp;
      offset_shifted = of;
      jump_req       = j;
      jump_target    = jt;
      e.pc  = e_pc;
      e.vld = e_v;
      e.rd  = e_r;
      e.cnt = e_c;
      e.af  = e_a;
      exp_q.push_back(e);
      nm_q.push_back(nm);
      @(negedge clk);
   endtask

   task automatic idle(input logic [15:0] e_pc, input logic e_v, input logic [7:0] e_c,
                       input logic e_a, input string nm);
      step(1'b0, 1'b0, 1'b0, 16'h0, 13'h0, 1'b0, 16'h0, e_pc, e_v, 1'b0, e_c, e_a, nm);
   endtask

   task automatic jump(input logic s, input logic [15:0] jt, input logic [15:0] e_pc,
                       input logic [7:0] e_c, input logic e_a, input string nm);
      step(1'b0, s, 1'b0, 16'h0, 13'h0, 1'b1, jt, e_pc, 1'b0, 1'b1, e_c, e_a, nm);
   endtask

   initial begin : monitor
      exp_t  e;
      string n;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            total++;
            if ({pc, pc_valid, redirect, redirect_count, align_fault} !== e) begin
               bad++;
               $display("FAIL %s: got pc=%h vld=%b rd=%b cnt=%h af=%b, want pc=%h vld=%b rd=%b cnt=%h af=%b",
                        n, pc, pc_valid, redirect, redirect_count, align_fault,
                        e.pc, e.vld, e.rd, e.cnt, e.af);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete within the time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_pc = '0;
      offset_shifted = '0; jump_req = 1'b0; jump_target = '0;
      @(negedge clk);

      step(1'b1, 1'b0, 1'b0, 16'h0, 13'h0, 1'b0, 16'h0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, "reset");
      idle(16'h0000, 1'b1, 8'h00, 1'b0, "first_fetch");
      idle(16'h0002, 1'b1, 8'h00, 1'b0, "seq_0002");
      idle(16'h0004, 1'b1, 8'h00, 1'b0, "seq_0004");
      for (int i = 0; i < 6; i++)
         idle(16'h0006 + 16'(2 * i), 1'b1, 8'h00, 1'b0, "seq_to_0010");

      // pc is 0010: branch back by 4 from 000E
      step(1'b0, 1'b0, 1'b1, 16'h000E, 13'h1FFC, 1'b0, 16'h0, 16'h000C, 1'b0, 1'b1, 8'h01, 1'b0, "branch_neg");
      idle(16'h000C, 1'b1, 8'h01, 1'b0, "after_branch");
      idle(16'h000E, 1'b1, 8'h01, 1'b0, "after_branch_seq");

      step(1'b0, 1'b0, 1'b1, 16'h0100, 13'h0020, 1'b1, 16'h4000, 16'h0122, 1'b0, 1'b1, 8'h02, 1'b0, "branch_beats_jump");
      idle(16'h0122, 1'b1, 8'h02, 1'b0, "after_collision");

      step(1'b0, 1'b0, 1'b1, 16'hFFFC, 13'h0008, 1'b0, 16'h0, 16'h0006, 1'b0, 1'b1, 8'h03, 1'b0, "branch_wrap");
      idle(16'h0006, 1'b1, 8'h03, 1'b0, "after_branch_wrap");

      jump(1'b0, 16'hFFFE, 16'hFFFE, 8'h04, 1'b0, "jump_fffe");
      idle(16'hFFFE, 1'b1, 8'h04, 1'b0, "fetch_fffe");
      idle(16'h0000, 1'b1, 8'h04, 1'b0, "seq_wrap");
      idle(16'h0002, 1'b1, 8'h04, 1'b0, "seq_after_wrap");

      jump(1'b0, 16'h0020, 16'h0020, 8'h05, 1'b0, "jump_0020");
      idle(16'h0020, 1'b1, 8'h05, 1'b0, "fetch_0020");
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 1'b0, 16'h0, 13'h0, 1'b0, 16'h0, 16'h0020, 1'b0, 1'b0, 8'h05, 1'b0, "stall_hold");
      jump(1'b1, 16'h0300, 16'h0300, 8'h06, 1'b0, "jump_during_stall");
      step(1'b0, 1'b1, 1'b0, 16'h0, 13'h0, 1'b0, 16'h0, 16'h0300, 1'b0, 1'b0, 8'h06, 1'b0, "bubble_to_stall");
      idle(16'h0300, 1'b1, 8'h06, 1'b0, "stall_release");
      idle(16'h0302, 1'b1, 8'h06, 1'b0, "seq_after_stall");

      jump(1'b0, 16'h0400, 16'h0400, 8'h07, 1'b0, "jump_0400");
      step(1'b0, 1'b0, 1'b1, 16'h0500, 13'h0004, 1'b0, 16'h0, 16'h0506, 1'b0, 1'b1, 8'h08, 1'b0, "redirect_in_bubble");
      idle(16'h0506, 1'b1, 8'h08, 1'b0, "after_back_to_back");

      jump(1'b0, 16'h0301, ODD_JPC, 8'h09, ODD_AF, "jump_odd");
      idle(ODD_JPC, 1'b1, 8'h09, ODD_AF, "odd_fetch");
      idle(ODD_JPC + 16'h0002, 1'b1, 8'h09, ODD_AF, "align_fault_sticky");
      step(1'b0, 1'b1, 1'b0, 16'h0, 13'h0, 1'b0, 16'h0, ODD_JPC + 16'h0002, 1'b0, 1'b0, 8'h09, ODD_AF, "stall_before_reset");

      step(1'b1, 1'b1, 1'b1, 16'h1234, 13'h0010, 1'b1, 16'h5555, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, "reset_mid_stall");
      idle(16'h0000, 1'b1, 8'h00, 1'b0, "fetch_after_reset");

      for (int i = 0; i < 260; i++)
         jump(1'b0, 16'h1000, 16'h1000, (i >= 254) ? 8'hFF : 8'(i + 1), 1'b0, "redirect_count");
      idle(16'h1000, 1'b1, 8'hFF, 1'b0, "count_saturated");
      step(1'b1, 1'b0, 1'b0, 16'h0, 13'h0, 1'b0, 16'h0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, "reset_clears_count");

      for (int k = 0; k < 5 && exp_q.size() > 0; k++)
         @(negedge clk);
      if (exp_q.size() > 0) begin
         bad++;
         $display("FAIL drain: %0d expected responses never compared, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the 16-bit processor's fetch stage. It consumes the 13-bit left-shifted branch offset produced by the shift-left-by-one unit, together with branch resolution and jump requests from later stages, and maintains the registered PC. The PC advances sequentially, redirects to branch or jump targets, and holds on stall. Each redirect inserts a one-cycle fetch bubble, and taken redirects are counted for performance debug.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- PC_INC, 2, sequential increment in bytes (one 16-bit instruction)

- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold PC; fetch not issued this cycle
- branch_taken  input  1  resolved taken branch this cycle (single-cycle pulse)
- branch_pc  input  16  PC of the resolving branch instruction
- offset_shifted  input  13  shifted branch offset (bit 0 always 0), two's complement
- jump_req  input  1  unconditional jump this cycle
- jump_target  input  16  absolute jump address
- pc  output  16  registered fetch address
- pc_valid  output  1  pc is a fetch request this cycle
- redirect  output  1  registered, high the cycle after a redirect is accepted
- redirect_count  output  8  saturating count of accepted redirects
- align_fault  output  1  misaligned jump target seen (see Configuration)

## Operation
- Decision: one clock, synchronous active-high reset on `reset`, port `clk`.
- Branch target = branch_pc + PC_INC + sign_extend16(offset_shifted), computed modulo 2^16. Wrap-around is silent. No overflow flag exists.
- Next-PC priority: reset > branch_taken > jump_req > stall > sequential (pc + PC_INC, mod 2^16).
- When branch_taken and jump_req are high in the same cycle, the branch wins (it is the older instruction) and the jump is dropped.
- States:
  - RUN: pc_valid=1. The PC advances or redirects.
  - STALL: pc_valid=0. The PC holds.
  - BUBBLE: pc_valid=0. This is the first cycle at a new target.
- Transitions:
  - Any state, redirect accepted → BUBBLE. The PC is loaded with the target, and stall does not block a redirect.
  - RUN, stall=1 and no redirect → STALL.
  - STALL, stall=0 → RUN.
  - BUBBLE, no redirect → RUN if stall=0, else STALL.
  - BUBBLE, redirect → stays in BUBBLE with the newer target.
- The PC is not advanced in BUBBLE or STALL. The instruction at the new target is fetched when the sequencer returns to RUN.
- redirect_count increments by 1 on every accepted redirect and saturates at 8'hFF. It clears only on reset.

## Timing
- Reset values: pc=RESET_PC, state=BUBBLE (so pc_valid=0), redirect=0, redirect_count=0, align_fault=0.
- The first fetch occurs on the second cycle after reset deasserts, if stall=0.
- Redirect latency: an input sampled at edge N gives pc=target after edge N. redirect=1 and pc_valid=0 for exactly that one cycle.
- Sequential latency: pc updates every edge in RUN.
- Reset asserted mid-redirect or mid-stall discards all pending state. The values at the next edge are the reset values.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - A jump with jump_target[0]=1 is accepted with bit 0 forced to 0.
  - align_fault is set and stays set until reset.
  - Branch targets are never checked, since they are aligned by construction.
- PC_ALIGN_CHECK_EN undefined:
  - jump_target is used unmodified.
  - align_fault is tied to 0.

## Test plan
- Reset with RESET_PC=16'h0000, then stall=0 for 4 cycles → pc_valid sequence 0,1,1,1 and pc = 0000, 0000, 0002, 0004.
- At pc=0010, branch_taken with branch_pc=000E and offset_shifted=13'h1FFC (−4) → next pc=000C, redirect=1, pc_valid=0, redirect_count=1. On the following cycle pc_valid=1.
- Simultaneous branch_taken (branch_pc=0100, offset=13'h0020) and jump_req (jump_target=4000) → pc=0122, and the jump is ignored.
- Wrap-around:
  - branch_pc=FFFC with offset_shifted=13'h0008 → pc=0006.
  - Sequential step from FFFE → 0000.
- Stall for 3 cycles in RUN at pc=0020 → pc holds at 0020 with pc_valid=0. A jump to 0300 arriving during the stall still redirects, giving pc=0300 and state BUBBLE.
- Alignment and saturation:
  - With PC_ALIGN_CHECK_EN, a jump to 0301 → pc=0300 and align_fault=1, which stays high.
  - 260 redirects → redirect_count=FF.
